// File: rtl/hazard_ctrl_if.sv
// Hazard control bundle between the pipeline datapath and hazard_ctrl.
// master = datapath side, slave = controller side.
interface hazard_ctrl_if #(
    parameter int NSTAGE = 5,
    parameter int RW     = 5,
    parameter int CW     = 16
);
    localparam int L = NSTAGE - 1;

    logic          ihit;
    logic          dhit;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] ex_rd;
    logic          ex_regWEN;
    logic          ex_dmemREN;
    logic          mem_dmemREN;
    logic          mem_dmemWEN;
    logic [1:0]    br_type;
    logic          zero;
    logic          halt;
    logic          pcen;
    logic [L-1:0]  en;
    logic [L-1:0]  flush;
    logic          halted;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    modport master (
        output ihit, dhit, id_rs, id_rt, ex_rd,
        output ex_regWEN, ex_dmemREN,
        output mem_dmemREN, mem_dmemWEN,
        output br_type, zero, halt,
        input  pcen, en, flush, halted,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, id_rs, id_rt, ex_rd,
        input  ex_regWEN, ex_dmemREN,
        input  mem_dmemREN, mem_dmemWEN,
        input  br_type, zero, halt,
        output pcen, en, flush, halted,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: static not-taken branches, load-use
// bubbles, fetch/data memory waits and sticky halt, with perf counters.
module hazard_ctrl #(
    parameter int NSTAGE   = 5,
    parameter int RW       = 5,
    parameter int LU_STALL = 1,
    parameter int BR_STG   = 2,
    parameter int CW       = 16
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_ctrl_if.slave  hz
);
    localparam int L = NSTAGE - 1;
    localparam logic [L-1:0] BR_MASK = {L{1'b1}} >> (L - 1 - BR_STG);

    typedef enum logic [1:0] {
        RUN,
        LUSTALL,
        HALTED
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          halted_q, halted_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [CW-1:0] fcnt_q, fcnt_d;

    logic [RW-1:0] rd;
    logic          mispred;
    logic          lu_haz;
    logic          lu_stall;
    logic          dwait;
    logic          pcen_o;
    logic [L-1:0]  en_o;
    logic [L-1:0]  flush_o;

    assign rd = hz.ex_rd;

    always_comb begin
        mispred = ((hz.br_type == 2'd1) & hz.zero)
                | ((hz.br_type == 2'd2) & ~hz.zero)
                | (hz.br_type == 2'd3);
        lu_haz  = hz.ex_dmemREN & hz.ex_regWEN & (rd != '0)
                & ((rd == hz.id_rs) | (rd == hz.id_rt));
        dwait   = (hz.mem_dmemREN | hz.mem_dmemWEN) & ~hz.dhit;
        lu_stall = (state_q == LUSTALL)
                 | ((state_q == RUN) & lu_haz);
    end

    always_comb begin
        pcen_o  = 1'b1;
        en_o    = '1;
        flush_o = '0;
        if (!RST) begin
            if (state_q == HALTED) begin
                pcen_o = 1'b0;
            end else if (dwait) begin
                pcen_o = 1'b0;
                en_o   = '0;
            end else begin
                if (mispred) begin
                    flush_o = BR_MASK;
                end else if (lu_stall) begin
                    pcen_o     = 1'b0;
                    en_o[0]    = 1'b0;
                    flush_o[1] = 1'b1;
                end else if (!hz.ihit) begin
                    pcen_o     = 1'b0;
                    en_o[0]    = 1'b0;
                    flush_o[0] = 1'b1;
                end
                // The halt cycle itself still lets lower-priority flushes act.
                if (hz.halt) pcen_o = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        stall_d  = stall_q;
        fcnt_d   = fcnt_q;
        if (state_q != HALTED) begin
            if (!pcen_o && stall_q != '1) stall_d = stall_q + CW'(1);
            if (!dwait) begin
                if (mispred && fcnt_q != '1) fcnt_d = fcnt_q + CW'(1);
                if (hz.halt) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                    cnt_d    = '0;
                end else if (mispred) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (state_q == RUN && lu_haz && LU_STALL > 1) begin
                    state_d = LUSTALL;
                    cnt_d   = 2'(LU_STALL - 1);
                end else if (state_q == LUSTALL) begin
                    if (cnt_q == 2'd1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            stall_q  <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            stall_q  <= stall_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign hz.pcen      = pcen_o;
    assign hz.en        = en_o;
    assign hz.flush     = flush_o;
    assign hz.halted    = halted_q;
    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = fcnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: one default instance and
// one LU_STALL=3 instance share the same stimulus.
module tb_hazard_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    hazard_ctrl_if b0 ();
    hazard_ctrl_if b3 ();

    hazard_ctrl u0 (
        .CLK(CLK),
        .RST(RST),
        .hz (b0.slave)
    );

    hazard_ctrl #(.LU_STALL(3)) u3 (
        .CLK(CLK),
        .RST(RST),
        .hz (b3.slave)
    );

    assign b3.ihit        = b0.ihit;
    assign b3.dhit        = b0.dhit;
    assign b3.id_rs       = b0.id_rs;
    assign b3.id_rt       = b0.id_rt;
    assign b3.ex_rd       = b0.ex_rd;
    assign b3.ex_regWEN   = b0.ex_regWEN;
    assign b3.ex_dmemREN  = b0.ex_dmemREN;
    assign b3.mem_dmemREN = b0.mem_dmemREN;
    assign b3.mem_dmemWEN = b0.mem_dmemWEN;
    assign b3.br_type     = b0.br_type;
    assign b3.zero        = b0.zero;
    assign b3.halt        = b0.halt;

    typedef struct {
        string       tag;
        bit          dut;
        logic        pcen;
        logic [3:0]  en;
        logic [3:0]  flush;
        logic        halted;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic idle();
        b0.ihit        = 1'b1;
        b0.dhit        = 1'b1;
        b0.id_rs       = '0;
        b0.id_rt       = '0;
        b0.ex_rd       = '0;
        b0.ex_regWEN   = 1'b0;
        b0.ex_dmemREN  = 1'b0;
        b0.mem_dmemREN = 1'b0;
        b0.mem_dmemWEN = 1'b0;
        b0.br_type     = 2'd0;
        b0.zero        = 1'b0;
        b0.halt        = 1'b0;
    endtask

    task automatic expect_out(input string tag, input bit dut,
                              input logic p, input logic [3:0] e,
                              input logic [3:0] f, input logic h,
                              input int sc, input int fc);
        exp_t x;
        x.tag = tag; x.dut = dut; x.pcen = p; x.en = e;
        x.flush = f; x.halted = h;
        x.sc = 16'(sc); x.fc = 16'(fc);
        q.push_back(x);
    endtask

    task automatic chk(input string tag, input string fld,
                       input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed %0h expected %0h",
                   tag, fld, obs, exp);
        end
    endtask

    task automatic cycle();
        exp_t x;
        logic        p, h;
        logic [3:0]  e, f;
        logic [15:0] s, c;
        @(negedge CLK);
        while (q.size() > 0) begin
            x = q.pop_front();
            if (x.dut) begin
                p = b3.pcen; e = b3.en; f = b3.flush; h = b3.halted;
                s = b3.stall_cnt; c = b3.flush_cnt;
            end else begin
                p = b0.pcen; e = b0.en; f = b0.flush; h = b0.halted;
                s = b0.stall_cnt; c = b0.flush_cnt;
            end
            chk(x.tag, "pcen", 16'(p), 16'(x.pcen));
            chk(x.tag, "en", 16'(e), 16'(x.en));
            chk(x.tag, "flush", 16'(f), 16'(x.flush));
            chk(x.tag, "halted", 16'(h), 16'(x.halted));
            chk(x.tag, "stall_cnt", s, x.sc);
            chk(x.tag, "flush_cnt", c, x.fc);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // reset masks garbage inputs
        b0.halt = 1'b1; b0.ihit = 1'b0; b0.br_type = 2'd3;
        expect_out("rst_out", 0, 1, 4'hF, 4'h0, 0, 0, 0);
        cycle();

        RST = 1'b0; idle();
        expect_out("run", 0, 1, 4'hF, 4'h0, 0, 0, 0);
        cycle();

        b0.ex_dmemREN = 1'b1; b0.ex_regWEN = 1'b1;
        b0.ex_rd = 5'd8; b0.id_rs = 5'd8;
        expect_out("lu1", 0, 0, 4'hE, 4'h2, 0, 0, 0);
        expect_out("lu3_a", 1, 0, 4'hE, 4'h2, 0, 0, 0);
        cycle();

        idle();
        expect_out("lu1_done", 0, 1, 4'hF, 4'h0, 0, 1, 0);
        expect_out("lu3_b", 1, 0, 4'hE, 4'h2, 0, 1, 0);
        cycle();
        expect_out("lu1_idle", 0, 1, 4'hF, 4'h0, 0, 1, 0);
        expect_out("lu3_c", 1, 0, 4'hE, 4'h2, 0, 2, 0);
        cycle();
        expect_out("lu3_done", 1, 1, 4'hF, 4'h0, 0, 3, 0);
        cycle();

        RST = 1'b1;
        expect_out("rst2", 0, 1, 4'hF, 4'h0, 0, 1, 0);
        cycle();

        RST = 1'b0;
        b0.br_type = 2'd1; b0.zero = 1'b1;
        expect_out("beq_taken", 0, 1, 4'hF, 4'h7, 0, 0, 0);
        cycle();

        b0.br_type = 2'd2; b0.zero = 1'b1;
        expect_out("bne_nt", 0, 1, 4'hF, 4'h0, 0, 0, 1);
        cycle();

        b0.zero = 1'b0;
        expect_out("bne_taken", 0, 1, 4'hF, 4'h7, 0, 0, 1);
        cycle();

        b0.br_type = 2'd3; b0.mem_dmemREN = 1'b1; b0.dhit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_out("dwait", 0, 0, 4'h0, 4'h0, 0, i, 2);
            cycle();
        end

        b0.dhit = 1'b1;
        expect_out("dwait_rel", 0, 1, 4'hF, 4'h7, 0, 4, 2);
        cycle();

        idle();
        expect_out("idle2", 0, 1, 4'hF, 4'h0, 0, 4, 3);
        cycle();

        b0.ex_dmemREN = 1'b1; b0.ex_regWEN = 1'b1;
        b0.ex_rd = 5'd0; b0.id_rs = 5'd0;
        expect_out("r0_load", 0, 1, 4'hF, 4'h0, 0, 4, 3);
        cycle();

        idle(); b0.ihit = 1'b0;
        expect_out("ifetch", 0, 0, 4'hE, 4'h1, 0, 4, 3);
        cycle();

        idle(); b0.halt = 1'b1;
        expect_out("halt_cyc", 0, 0, 4'hF, 4'h0, 0, 5, 3);
        cycle();

        idle();
        expect_out("halted", 0, 0, 4'hF, 4'h0, 1, 6, 3);
        cycle();

        b0.br_type = 2'd3; b0.ihit = 1'b0;
        b0.ex_dmemREN = 1'b1; b0.ex_regWEN = 1'b1;
        b0.ex_rd = 5'd4; b0.id_rt = 5'd4;
        expect_out("halted_busy", 0, 0, 4'hF, 4'h0, 1, 6, 3);
        cycle();

        b0.mem_dmemWEN = 1'b1; b0.dhit = 1'b0;
        expect_out("halted_dw", 0, 0, 4'hF, 4'h0, 1, 6, 3);
        cycle();

        idle(); RST = 1'b1;
        expect_out("rst_halt", 0, 1, 4'hF, 4'h0, 1, 6, 3);
        cycle();

        RST = 1'b0;
        expect_out("post_rst", 0, 1, 4'hF, 4'h0, 0, 0, 0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
